// File: rtl/marauder_pkg.sv
// Shared types for the marauder instruction sequencer: ALU opcodes, FSM
// states, the packed instruction layout and write-bank constants.
package marauder_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_NOR  = 3'b100,
    OP_XOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_NAND = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  typedef struct packed {
    alu_op_t    opcode;
    logic [2:0] rd_a;
    logic [2:0] rd_b;
    logic [6:0] wrt_slct;
  } instr_t;

  localparam logic [3:0] BANK_A = 4'h0;
  localparam logic [3:0] BANK_B = 4'h1;

  // Only banks A and B exist in the register file; anything else is dropped.
  function automatic logic bank_ok(input logic [6:0] sel);
    return (sel[6:3] == BANK_A) || (sel[6:3] == BANK_B);
  endfunction

endpackage

// File: rtl/marauder_seq.sv
// Instruction sequencer driving the register file / ALU pair: one instruction
// every four cycles (IDLE, READ, EXEC, WRITE), with a retired-instruction count.
module marauder_seq
  import marauder_pkg::*;
#(
  parameter int         CNT_W    = 16,
  // Must not be 3'b000 or 3'b001: those indices have read side effects.
  parameter logic [2:0] PARK_SEL = 3'b010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [7:0]       alu_c,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic [2:0]       opcode,
  output logic [2:0]       rd_slct_a,
  output logic [2:0]       rd_slct_b,
  output logic [6:0]       wrt_slct,
  output logic             wrtnbl,
  output logic [7:0]       data_out,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             illegal_wr,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is only high in IDLE, so a valid
  // offered while busy is ignored and instr may change freely after transfer.

  localparam instr_t INSTR_RST = '{
    opcode:   OP_ADD,
    rd_a:     PARK_SEL,
    rd_b:     PARK_SEL,
    wrt_slct: 7'h00
  };

  state_t           state, state_n;
  instr_t           instr_q, instr_q_n;
  logic [7:0]       result, result_n;
  logic             ready_n;
  logic             flag_zero_n, flag_carry_n;
  logic             wrtnbl_n, illegal_n, done_n;
  logic [CNT_W-1:0] retired_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr_q     <= INSTR_RST;
      result      <= 8'h00;
      instr_ready <= 1'b1;
      flag_zero   <= 1'b0;
      flag_carry  <= 1'b0;
      wrtnbl      <= 1'b0;
      illegal_wr  <= 1'b0;
      done        <= 1'b0;
      retired     <= '0;
    end else begin
      state       <= state_n;
      instr_q     <= instr_q_n;
      result      <= result_n;
      instr_ready <= ready_n;
      flag_zero   <= flag_zero_n;
      flag_carry  <= flag_carry_n;
      wrtnbl      <= wrtnbl_n;
      illegal_wr  <= illegal_n;
      done        <= done_n;
      retired     <= retired_n;
    end
  end

  // Strobes are computed while in EXEC so that, registered, they sit exactly
  // on the WRITE cycle alongside the freshly captured result and flags.
  always_comb begin
    state_n      = state;
    instr_q_n    = instr_q;
    result_n     = result;
    ready_n      = instr_ready;
    flag_zero_n  = flag_zero;
    flag_carry_n = flag_carry;
    wrtnbl_n     = 1'b0;
    illegal_n    = 1'b0;
    done_n       = 1'b0;
    retired_n    = retired;
    case (state)
      S_IDLE: begin
        ready_n = 1'b1;
        if (instr_valid && instr_ready) begin
          instr_q_n = instr_t'(instr);
          ready_n   = 1'b0;
          state_n   = S_READ;
        end
      end
      S_READ: begin
        state_n = S_EXEC;
      end
      S_EXEC: begin
        result_n     = alu_c;
        flag_zero_n  = alu_zero;
        flag_carry_n = alu_carry;
        done_n       = 1'b1;
        retired_n    = retired + CNT_W'(1);
        if (bank_ok(instr_q.wrt_slct)) begin
          wrtnbl_n = 1'b1;
        end else begin
          illegal_n = 1'b1;
        end
        state_n = S_WRITE;
      end
      S_WRITE: begin
        ready_n = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Selects come straight from the latched instruction, so they only move on accept.
  assign opcode    = instr_q.opcode;
  assign rd_slct_a = instr_q.rd_a;
  assign rd_slct_b = instr_q.rd_b;
  assign wrt_slct  = instr_q.wrt_slct;
  assign data_out  = result;

endmodule

// File: tb/tb_marauder_seq.sv
// Randomized scoreboard bench for marauder_seq: a driver issues instructions
// and ALU responses, a monitor checks every WRITE cycle against a queue.
module tb_marauder_seq;

  localparam int         CNT_W = 4;
  localparam logic [2:0] PARK  = 3'b010;

  logic             clk;
  logic             rst_n;
  logic [15:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [7:0]       alu_c;
  logic             alu_zero;
  logic             alu_carry;
  logic [2:0]       opcode;
  logic [2:0]       rd_slct_a;
  logic [2:0]       rd_slct_b;
  logic [6:0]       wrt_slct;
  logic             wrtnbl;
  logic [7:0]       data_out;
  logic             flag_zero;
  logic             flag_carry;
  logic             illegal_wr;
  logic             done;
  logic [CNT_W-1:0] retired;

  marauder_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_c(alu_c), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .opcode(opcode), .rd_slct_a(rd_slct_a),
    .rd_slct_b(rd_slct_b), .wrt_slct(wrt_slct), .wrtnbl(wrtnbl),
    .data_out(data_out), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .illegal_wr(illegal_wr), .done(done), .retired(retired)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          n_vec;
  int          n_fail;
  int          retired_model;
  logic [2:0]  exp_rd_a;
  logic [2:0]  exp_rd_b;
  bit          mon_en;
  bit          ready_pending;
  longint      last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected WRITE-cycle picture built from the instruction fields and ALU inputs.
  function automatic logic [31:0] pack_exp(input logic [15:0] ins, input logic [7:0] a,
                                           input logic z, input logic cy, input int cnt);
    logic legal;
    legal = (ins[6:3] == 4'h0) || (ins[6:3] == 4'h1);
    return {4'(cnt), ins[6:0], a, legal, !legal, z, cy, ins[15:13], ins[12:10], ins[9:7]};
  endfunction

  task automatic alu_noise();
    alu_c     = 8'($urandom);
    alu_zero  = 1'($urandom);
    alu_carry = 1'($urandom);
  endtask

  // Entered and left on a falling edge; returns on the WRITE cycle.
  task automatic send(input logic [15:0] ins, input logic [7:0] a, input logic z,
                      input logic cy, input bit hold, input bit abort);
    int t;
    instr       = ins;
    instr_valid = 1'b1;
    t = 0;
    while (instr_ready !== 1'b1) begin
      @(negedge clk);
      t++;
      if (t > 20) begin
        chk("accept_timeout", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    last_acc = longint'($time);
    #1;
    exp_rd_a = ins[12:10];
    exp_rd_b = ins[9:7];
    if (!hold) instr_valid = 1'b0;
    instr = 16'($urandom);
    @(negedge clk);
    alu_noise();
    @(negedge clk);
    if (abort) begin
      #1;
      rst_n = 1'b0;
      retired_model = 0;
      exp_rd_a = PARK;
      exp_rd_b = PARK;
      #1;
      chk("abort_strobes", {29'd0, wrtnbl, done, illegal_wr}, 32'd0);
      chk("abort_sel", {26'd0, rd_slct_a, rd_slct_b}, {26'd0, PARK, PARK});
      chk("abort_regs", {8'd0, opcode, wrt_slct, data_out, flag_zero, flag_carry, instr_ready},
          {8'd0, 3'd0, 7'd0, 8'd0, 1'b0, 1'b0, 1'b1});
      chk("abort_retired", 32'(retired), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    alu_c     = a;
    alu_zero  = z;
    alu_carry = cy;
    retired_model = (retired_model + 1) % (1 << CNT_W);
    exp_q.push_back(pack_exp(ins, a, z, cy, retired_model));
    @(negedge clk);
    alu_noise();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rd_sel_stable", {26'd0, rd_slct_a, rd_slct_b}, {26'd0, exp_rd_a, exp_rd_b});
      if (ready_pending) begin
        chk("ready_after_write", {31'd0, instr_ready}, 32'd1);
        ready_pending = 1'b0;
      end
      if (done === 1'b1) begin
        chk("ready_low_in_write", {31'd0, instr_ready}, 32'd0);
        ready_pending = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          chk("write_cycle",
              {retired, wrt_slct, data_out, wrtnbl, illegal_wr, flag_zero, flag_carry,
               opcode, rd_slct_a, rd_slct_b},
              exp_q.pop_front());
        end
      end else begin
        chk("strobe_outside_write", {30'd0, wrtnbl, illegal_wr}, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ins;
    logic [3:0]  bank;
    longint      t1;
    bit          hold;
    n_vec = 0; n_fail = 0; retired_model = 0;
    mon_en = 1'b0; ready_pending = 1'b0;
    exp_rd_a = PARK; exp_rd_b = PARK;
    rst_n = 1'b0; instr = 16'h0000; instr_valid = 1'b0;
    alu_noise();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_sel", {26'd0, rd_slct_a, rd_slct_b}, {26'd0, PARK, PARK});
    chk("reset_regs", {2'd0, opcode, wrt_slct, data_out, wrtnbl, flag_zero, flag_carry,
                       illegal_wr, done, instr_ready, retired},
        {2'd0, 3'd0, 7'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
    mon_en = 1'b1;

    // Reset during EXEC: nothing retires, everything returns to reset values.
    send(16'h0984, 8'h5a, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    chk("post_abort_retired", 32'(retired), 32'd0);

    // ADD rd_a=2 rd_b=3 -> A4
    send(16'h0984, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_write", {14'd0, wrtnbl, wrt_slct, data_out, done, retired},
        {14'd0, 1'b1, 7'h04, 8'h07, 1'b1, 4'd1});
    @(negedge clk);

    // SUB with carry set, zero clear
    send(16'h2984, 8'h3c, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sub_flags", {30'd0, flag_carry, flag_zero}, {30'd0, 1'b1, 1'b0});
    @(negedge clk);
    chk("sub_flags_hold", {30'd0, flag_carry, flag_zero}, {30'd0, 1'b1, 1'b0});

    // Write to bank 2 is suppressed and flagged
    send(16'h0990, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("illegal_write", {29'd0, wrtnbl, illegal_wr, done}, {29'd0, 3'b011});
    chk("illegal_retired", 32'(retired), 32'd3);

    // Back-to-back, identical read selects, valid held high
    send(16'ha_b55, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    t1 = last_acc;
    send(16'h4_b0b, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("b2b_spacing", 32'(last_acc - t1), 32'd40);

    // Randomized traffic; wraps the 4-bit counter several times
    for (int i = 0; i < 40; i++) begin
      bank = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 1)) : 4'($urandom);
      ins  = {3'($urandom), 3'($urandom), 3'($urandom), bank, 3'($urandom)};
      hold = (i != 39) && ($urandom_range(0, 1) == 1);
      send(ins, 8'($urandom), 1'($urandom), 1'($urandom), hold, 1'b0);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    instr_valid = 1'b0;

    repeat (10) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
